dmem_arbiter: RTL

Shares the core's single byte-wide data-memory port between the core load/store unit (LSU) and the external byte loader. LSU accesses of 1/2/4/8 bytes are serialised into consecutive byte beats and read bytes are reassembled. Single-byte external accesses are interleaved by round-robin. It sits between the LSU/external-loader front ends and the data memory, and stalls the core pipeline while an LSU access is in flight.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/dmem_byte_lane.sv | 27 ++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states, owner ids.
// No logic here; the helper maps an access size to its last beat index.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic OWN_LSU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [2:0] last_beat(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd0;
      SIZE_H:  return 3'd1;
      SIZE_W:  return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles the LSU, external-loader and byte-wide memory signals of the arbiter.
// slave is the arbiter's view; master is the view of the front ends plus memory.
interface dmem_arbiter_if #(
  parameter int BUS_WIDTH = 64
);

  logic                 running;
  logic                 lsu_req;
  logic                 lsu_we;
  logic [1:0]           lsu_size;
  logic [BUS_WIDTH-1:0] lsu_addr;
  logic [BUS_WIDTH-1:0] lsu_wdata;
  logic [BUS_WIDTH-1:0] lsu_rdata;
  logic                 lsu_done;
  logic                 lsu_stall;

  logic                 ext_req;
  logic                 ext_we;
  logic [BUS_WIDTH-1:0] ext_addr;
  logic [7:0]           ext_wdata;
  logic [7:0]           ext_rdata;
  logic                 ext_ack;

  logic                 mem_en;
  logic                 mem_we;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [7:0]           mem_din;
  logic [7:0]           mem_dout;

  modport slave (
    input  running, lsu_req, lsu_we, lsu_size, lsu_addr, lsu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, mem_dout,
    output lsu_rdata, lsu_done, lsu_stall, ext_rdata, ext_ack,
    output mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output running, lsu_req, lsu_we, lsu_size, lsu_addr, lsu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata, mem_dout,
    input  lsu_rdata, lsu_done, lsu_stall, ext_rdata, ext_ack,
    input  mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/dmem_byte_lane.sv
// Byte-lane steering: picks the write byte for the current beat and merges a
// returned read byte into its lane of the capture word. Purely combinational.
module dmem_byte_lane #(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0] wdata,
  input  logic [2:0]           wr_sel,
  output logic [7:0]           wr_byte,
  input  logic [BUS_WIDTH-1:0] cap,
  input  logic                 cap_vld,
  input  logic [2:0]           cap_sel,
  input  logic [7:0]           rd_byte,
  output logic [BUS_WIDTH-1:0] cap_next
);

  localparam int LANES = BUS_WIDTH / 8;

  always_comb begin
    wr_byte  = '0;
    cap_next = cap;
    for (int i = 0; i < LANES; i++) begin
      if (wr_sel == 3'(i)) wr_byte = wdata[i*8 +: 8];
      if (cap_vld && (cap_sel == 3'(i))) cap_next[i*8 +: 8] = rd_byte;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin share of a byte-wide data memory between the LSU (1..8 byte beats) and
// an external byte port; N-beat access completes N+1 edges after grant, no preemption.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic          sys_clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic [2:0]           beat_q, beat_d;
  logic [2:0]           last_beat_q, last_beat_d;
  logic [BUS_WIDTH-1:0] base_q, base_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [BUS_WIDTH-1:0] cap_q, cap_d;
  logic                 cap_vld_q, cap_vld_d;
  logic [2:0]           cap_lane_q, cap_lane_d;
  logic [BUS_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;
  logic [7:0]           ext_rdata_q, ext_rdata_d;

  logic                 lsu_cand, ext_cand, grant_lsu, grant_ext;
  logic [7:0]           wr_byte;
  logic [BUS_WIDTH-1:0] cap_next;
  logic                 mem_en, mem_we;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [7:0]           mem_din;

  dmem_byte_lane #(.BUS_WIDTH(BUS_WIDTH)) u_lane (
    .wdata    (wdata_q),
    .wr_sel   (beat_q),
    .wr_byte  (wr_byte),
    .cap      (cap_q),
    .cap_vld  (cap_vld_q),
    .cap_sel  (cap_lane_q),
    .rd_byte  (bus.mem_dout),
    .cap_next (cap_next)
  );

  // On a tie the side that did not win last time is granted.
  assign lsu_cand  = bus.lsu_req & bus.running;
  assign ext_cand  = bus.ext_req;
  assign grant_lsu = lsu_cand & (~ext_cand | (last_grant_q == OWN_EXT));
  assign grant_ext = ext_cand & ~grant_lsu;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    last_beat_d  = last_beat_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    cap_d        = cap_next;
    cap_vld_d    = 1'b0;
    cap_lane_d   = beat_q;
    lsu_rdata_d  = lsu_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;

    case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          base_d       = bus.lsu_addr;
          wdata_d      = bus.lsu_wdata;
          we_d         = bus.lsu_we;
          last_beat_d  = last_beat(bus.lsu_size);
          beat_d       = 3'd0;
          cap_d        = '0;
          state_d      = ISSUE;
        end else if (grant_ext) begin
          owner_d      = OWN_EXT;
          last_grant_d = OWN_EXT;
          base_d       = bus.ext_addr;
          wdata_d      = {{(BUS_WIDTH-8){1'b0}}, bus.ext_wdata};
          we_d         = bus.ext_we;
          last_beat_d  = 3'd0;
          beat_d       = 3'd0;
          cap_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_q + {{(BUS_WIDTH-3){1'b0}}, beat_q};
        mem_din   = wr_byte;
        cap_vld_d = ~we_q;
        if (beat_q == last_beat_q) begin
          state_d = DRAIN;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      DRAIN: begin
        // cap_next already holds the final byte, so results publish on the DONE entry edge.
        state_d = DONE;
        if (!we_q) begin
          if (owner_q == OWN_LSU) lsu_rdata_d = cap_next;
          else                    ext_rdata_d = cap_next[7:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_LSU;
      last_grant_q <= OWN_EXT;
      beat_q       <= '0;
      last_beat_q  <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cap_q        <= '0;
      cap_vld_q    <= 1'b0;
      cap_lane_q   <= '0;
      lsu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      last_beat_q  <= last_beat_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cap_q        <= cap_d;
      cap_vld_q    <= cap_vld_d;
      cap_lane_q   <= cap_lane_d;
      lsu_rdata_q  <= lsu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign bus.lsu_done  = (state_q == DONE) && (owner_q == OWN_LSU);
  assign bus.ext_ack   = (state_q == DONE) && (owner_q == OWN_EXT);
  assign bus.lsu_stall = bus.lsu_req & ~bus.lsu_done;
  assign bus.lsu_rdata = lsu_rdata_q;
  assign bus.ext_rdata = ext_rdata_q;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_din   = mem_din;

endmodule
